// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit-side FSM state encodings.
// Used by uart_tx_fifo now and intended for the uart and a future uart_rx_fifo.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAIN  = 2'd2
  } uart_tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x UART_DW register array: synchronous write, asynchronous read.
// Contents are not reset; the owning FIFO's pointers/level define validity.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [UART_DW-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [UART_DW-1:0] o_rdata
);

  logic [UART_DW-1:0] r_mem [DEPTH];

  // Store the incoming byte at the write address on an accepted write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Head byte is always presented combinationally at the read address.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart tx_en/tx_data/tx_busy handshake.
// Optional sticky overflow flag (ports ovf/ovf_clr) when UART_TX_FIFO_OVF_STICKY_EN
// is defined; without it, writes into a full FIFO are dropped silently.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | tx_en low; pop the head byte when data waits and uart is free
// ST_LAUNCH | tx_en high with tx_data held; wait for uart to raise tx_busy
// ST_DRAIN  | tx_en low; wait for the frame to finish (tx_busy low)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
`ifdef UART_TX_FIFO_OVF_STICKY_EN
  output logic               ovf,
  input  logic               ovf_clr,
`endif
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level,
  output logic               tx_en,
  output logic [UART_DW-1:0] tx_data,
  input  logic               tx_busy
);

  uart_tx_state_e     r_state;
  uart_tx_state_e     w_state_nxt;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic [AW:0]        w_level_nxt;
  logic               r_full;
  logic               r_empty;
  logic [UART_DW-1:0] r_tx_data;
  logic [UART_DW-1:0] w_mem_rdata;
  logic               w_wr_acc;
  logic               w_pop;
  logic               w_tx_en;

  // A write is accepted only if the FIFO was not full before the edge.
  always_comb begin
    w_wr_acc = wr_en && !r_full;
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (sys_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // FSM state register; async reset drops tx_en immediately, even mid-frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pop)    w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: if (tx_busy)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!tx_busy) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: tx_en while launching, pop strobe when idle with data and a free uart.
  always_comb begin
    w_tx_en = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      ST_IDLE:   w_pop   = !r_empty && !tx_busy;
      ST_LAUNCH: w_tx_en = 1'b1;
      default: begin
        w_tx_en = 1'b0;
        w_pop   = 1'b0;
      end
    endcase
  end

  // Occupancy after this edge; simultaneous accept and pop cancel out.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_pop})
      2'b10:   w_level_nxt = r_level + (AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers, level and flags all move on the same edge; pointers wrap naturally.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // tx_data only changes on a pop so the uart sees a stable byte through the frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_tx_data <= w_mem_rdata;
    end
  end

`ifdef UART_TX_FIFO_OVF_STICKY_EN
  logic r_ovf;

  // Sticky overflow: set on a dropped write, which takes priority over clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (wr_en && r_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;
  assign tx_en   = w_tx_en;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small uart model: tx_busy rises at the
// falling edge after tx_en is seen and stays high for 10 cycles; each launched
// byte is recorded in rx_q.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic               sys_clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [UART_DW-1:0] wr_data;
  logic               full;
  logic               empty;
  logic [AW:0]        level;
  logic               tx_en;
  logic [UART_DW-1:0] tx_data;
  logic               tx_busy;
`ifdef UART_TX_FIFO_OVF_STICKY_EN
  logic               ovf;
  logic               ovf_clr;
`endif

  logic       force_busy = 1'b0;
  logic       m_busy     = 1'b0;
  int         m_cnt      = 0;
  logic [7:0] rx_q[$];
  int         checks     = 0;
  int         failures   = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
`ifdef UART_TX_FIFO_OVF_STICKY_EN
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
`endif
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  assign tx_busy = force_busy | m_busy;

  always @(negedge sys_clk) begin
    if (m_cnt > 0) begin
      m_cnt  = m_cnt - 1;
      m_busy = (m_cnt != 0);
    end else if (tx_en) begin
      rx_q.push_back(tx_data);
      m_cnt  = 10;
      m_busy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while (!(empty && !tx_en && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_tx_en",   32'(tx_en),   32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
`ifdef UART_TX_FIFO_OVF_STICKY_EN
    chk("rst_ovf",     32'(ovf),     32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();

    // Single byte: tx_en two edges after the write, drops once busy is seen.
    push(8'h41);
    chk("one_lvl_e0",   32'(level),   32'd1);
    chk("one_empty_e0", 32'(empty),   32'd0);
    chk("one_txen_e0",  32'(tx_en),   32'd0);
    tick();
    chk("one_txen_e1",  32'(tx_en),   32'd1);
    chk("one_data_e1",  32'(tx_data), 32'h41);
    chk("one_lvl_e1",   32'(level),   32'd0);
    chk("one_empty_e1", 32'(empty),   32'd1);
    tick();
    chk("one_busy_e2",  32'(tx_busy), 32'd1);
    chk("one_txen_e2",  32'(tx_en),   32'd0);
    wait_drained(100);
    chk("one_rx_n",     32'(rx_q.size()), 32'd1);
    chk("one_rx_0",     32'(rx_q[0]),     32'h41);
    rx_q.delete();

    // Back-to-back A,B,C: A pops at the edge that writes B.
    push(8'h41);
    chk("abc_lvl_a",  32'(level),   32'd1);
    push(8'h42);
    chk("abc_lvl_b",  32'(level),   32'd1);
    chk("abc_txen_b", 32'(tx_en),   32'd1);
    chk("abc_data_b", 32'(tx_data), 32'h41);
    push(8'h43);
    chk("abc_lvl_c",  32'(level),   32'd2);
    chk("abc_data_c", 32'(tx_data), 32'h41);
    wait_drained(200);
    chk("abc_rx_n",   32'(rx_q.size()), 32'd3);
    chk("abc_rx_0",   32'(rx_q[0]), 32'h41);
    chk("abc_rx_1",   32'(rx_q[1]), 32'h42);
    chk("abc_rx_2",   32'(rx_q[2]), 32'h43);
    chk("abc_lvl_end",   32'(level), 32'd0);
    chk("abc_empty_end", 32'(empty), 32'd1);
    rx_q.delete();

    // Overfill with uart held busy: last two bytes dropped.
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(8'(8'h80 + i));
      if (i == DEPTH - 2) begin
        chk("ovr_full_m1", 32'(full),  32'd0);
        chk("ovr_lvl_m1",  32'(level), 32'd15);
      end
      if (i == DEPTH - 1) chk("ovr_full_at", 32'(full), 32'd1);
    end
    chk("ovr_full",  32'(full),  32'd1);
    chk("ovr_level", 32'(level), 32'd16);
    chk("ovr_empty", 32'(empty), 32'd0);
    chk("ovr_txen",  32'(tx_en), 32'd0);
    chk("ovr_rx_n",  32'(rx_q.size()), 32'd0);
`ifdef UART_TX_FIFO_OVF_STICKY_EN
    chk("ovr_ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovr_ovf_clr", 32'(ovf), 32'd0);
`endif
    force_busy = 1'b0;
    wait_drained(1000);
    chk("ovr_out_n", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovr_out_byte", 32'(rx_q[i]), 32'(8'h80 + i));
    end
    rx_q.delete();

    // Write at level DEPTH-1 on the same edge as a pop.
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) push(8'(8'h10 + i));
    chk("same_lvl_pre",  32'(level), 32'd15);
    chk("same_full_pre", 32'(full),  32'd0);
    force_busy = 1'b0;
    push(8'h55);
    chk("same_lvl_post", 32'(level),   32'd15);
    chk("same_txen",     32'(tx_en),   32'd1);
    chk("same_data",     32'(tx_data), 32'h10);
    wait_drained(1000);
    chk("same_out_n", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("same_out_byte", 32'(rx_q[i]), 32'(8'h10 + i));
    end
    chk("same_out_last", 32'(rx_q[DEPTH-1]), 32'h55);
    rx_q.delete();

    // Pointer wrap: three full rounds of an incrementing sequence.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) push(8'(r * DEPTH + i));
      wait_drained(1000);
    end
    chk("wrap_out_n", 32'(rx_q.size()), 32'd48);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      chk("wrap_out_byte", 32'(rx_q[k]), 32'(k));
    end
    rx_q.delete();

    // Async reset while launching: tx_en drops at once, queued byte discarded.
    push(8'h77);
    push(8'h78);
    chk("rstl_txen_pre", 32'(tx_en), 32'd1);
    chk("rstl_lvl_pre",  32'(level), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstl_txen",  32'(tx_en),   32'd0);
    chk("rstl_level", 32'(level),   32'd0);
    chk("rstl_empty", 32'(empty),   32'd1);
    chk("rstl_full",  32'(full),    32'd0);
    chk("rstl_data",  32'(tx_data), 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rstl_rx_n",      32'(rx_q.size()), 32'd0);
    chk("rstl_txen_end",  32'(tx_en), 32'd0);
    chk("rstl_empty_end", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
